// File: rtl/uart_program_loader.sv
// Boot-image loader: takes a little-endian word count and then that many words from the UART RX
// stream, writes each word to memory, and answers the host with a single ACK or NAK byte.
module uart_program_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MAX_WORDS  = 16384,
  parameter logic [7:0]            ACK_BYTE   = 8'hAA,
  parameter logic [7:0]            NAK_BYTE   = 8'h55
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // LEN   | collecting the 4-byte word count
  // CHECK | classifying the word count (empty / too large / load)
  // DATA  | collecting the 4 bytes of the current word
  // WRITE | presenting the word to memory
  // ACK   | sending ACK_BYTE to the host
  // NAK   | sending NAK_BYTE to the host
  // DONE  | load finished; waiting for a re-arm
  // ERROR | header rejected; waiting for a re-arm
  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_CHECK, S_DATA, S_WRITE, S_ACK, S_NAK, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] index, length, word;
  logic [31:0] index_inc;
  logic        arm;

  assign index_inc = index + 32'd1;
  assign arm       = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign mem_addr  = BASE_ADDR + (ADDR_WIDTH'(index) << 2);
  assign mem_wdata = word;

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    mem_valid  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_cnt == 2'd3) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (length == 32'd0)                  state_next = S_ACK;
        else if (length > 32'(MAX_WORDS))     state_next = S_NAK;
        else                                  state_next = S_DATA;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_cnt == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_valid = 1'b1;
        if (mem_ready) state_next = (index_inc == length) ? S_ACK : S_DATA;
      end
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) state_next = S_DONE;
      end
      S_NAK: begin
        tx_valid = 1'b1;
        tx_data  = NAK_BYTE;
        if (tx_ready) state_next = S_ERROR;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_next = S_LEN;
      end
      S_ERROR: begin
        busy = 1'b0;
        err  = 1'b1;
        if (start) state_next = S_LEN;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      index    <= 32'd0;
      length   <= 32'd0;
      word     <= 32'd0;
    end else begin
      state <= state_next;
      if (arm) begin
        byte_cnt <= 2'd0;
        index    <= 32'd0;
        length   <= 32'd0;
      end
      // Bytes shift in from the top, so after four of them the first byte sits in bits [7:0].
      if (rx_ready && rx_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_LEN) length <= {rx_data, length[31:8]};
        else                word   <= {rx_data, word[31:8]};
      end
      if (mem_valid && mem_ready) index <= index_inc;
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed and randomized boot images, checked against expected
// memory writes and host responses worked out from the image contents.
module tb_uart_program_loader;
  localparam int          AW        = 32;
  localparam logic [31:0] BASE      = 32'h0;
  localparam int unsigned MAX_WORDS = 16384;

  logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0, rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_valid, mem_ready = 1'b1;
  logic          busy, done, err;

  int checks = 0, errors = 0;
  logic rand_rx = 1'b0, rand_tx = 1'b0, rand_mem = 1'b0, tx_force = 1'b1, mem_force = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  logic [7:0]  tx_q[$];

  uart_program_loader dut (
    .clk(clk), .rstn(rstn), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Sink-side ready signals, updated away from the edge.
  always @(posedge clk) begin
    #2;
    tx_ready  = rand_tx  ? 1'($urandom_range(0, 1)) : tx_force;
    mem_ready = rand_mem ? 1'($urandom_range(0, 1)) : mem_force;
  end

  always @(posedge clk) begin
    if (rstn) begin
      if (mem_valid && mem_ready) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {rx_ready, tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, busy, done, err}, '0);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    logic hs;
    if (rand_rx) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 500) begin
      @(posedge clk);
      hs = rx_ready;
      #1;
      n++;
    end
    rx_valid = 1'b0;
    chk("rx_accept_timeout", hs, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    chk("mem_valid_latency", mem_valid, 1'b1);
  endtask

  task automatic send_image(input logic [31:0] len, input int nwords);
    send_word_hdr(len);
    for (int i = 0; i < nwords; i++) send_word(exp_q[i]);
  endtask

  task automatic send_word_hdr(input logic [31:0] len);
    for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Reference: an accepted header of len words yields len sequential writes plus one ACK;
  // an oversize header yields no writes and a NAK.
  task automatic check_result(input string tag, input logic [31:0] len);
    int   nexp;
    logic ok;
    ok   = (len <= MAX_WORDS);
    nexp = ok ? int'(len) : 0;
    chk({tag, "_wr_count"}, wr_addr_q.size(), nexp);
    for (int i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
      chk({tag, "_wr_addr"}, wr_addr_q[i], BASE + 32'(4 * i));
      chk({tag, "_wr_data"}, wr_data_q[i], exp_q[i]);
    end
    chk({tag, "_tx_count"}, tx_q.size(), 1);
    if (tx_q.size() > 0) chk({tag, "_tx_byte"}, tx_q[0], ok ? 8'hAA : 8'h55);
    chk({tag, "_flags"}, {busy, done, err}, {1'b0, ok, !ok});
  endtask

  initial begin
    // Reset and idle behaviour
    rstn = 1'b0;
    repeat (3) step();
    chk_idle("rst_hold");
    rstn = 1'b1;
    step();
    chk_idle("rst_release");
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    repeat (3) begin
      step();
      chk("rx_ready_idle", rx_ready, 1'b0);
    end
    rx_valid = 1'b0;

    // Two-word image, free-flowing sinks
    clear_logs();
    exp_q.delete();
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hDEADBEEF);
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    send_image(32'd2, 2);
    wait_idle();
    check_result("basic", 32'd2);

    // Same image with the first write stalled for 7 cycles
    clear_logs();
    pulse_start();
    chk("rearm_clears_done", {busy, done}, 2'b10);
    send_word_hdr(32'd2);
    mem_force = 1'b0;
    send_word(exp_q[0]);
    for (int c = 0; c < 8; c++) begin
      if (c == 7) mem_force = 1'b1;
      chk("stall_hold", {mem_valid, mem_addr, mem_wdata, rx_ready}, {1'b1, BASE, exp_q[0], 1'b0});
      step();
    end
    chk("stall_no_early_write", wr_addr_q.size(), 1);
    send_word(exp_q[1]);
    wait_idle();
    check_result("stall", 32'd2);

    // Empty image
    clear_logs();
    exp_q.delete();
    pulse_start();
    send_image(32'd0, 0);
    wait_idle();
    check_result("empty", 32'd0);

    // Oversize header, then re-arm
    clear_logs();
    pulse_start();
    send_image(32'd16385, 0);
    wait_idle();
    check_result("oversize", 32'd16385);
    pulse_start();
    chk("rearm_after_err", {busy, done, err}, 3'b100);

    // Reset in the middle of word 1 of a 3-word image
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back($urandom);
    pulse_start();
    send_word_hdr(32'd3);
    send_word(exp_q[0]);
    send_byte(exp_q[1][7:0]);
    send_byte(exp_q[1][15:8]);
    chk("mid_busy", {busy, rx_ready}, 2'b11);
    #2;
    rstn = 1'b0;
    #1;
    chk_idle("async_rst");
    step();
    rstn = 1'b1;
    step();
    clear_logs();
    exp_q.delete();
    exp_q.push_back($urandom);
    pulse_start();
    send_image(32'd1, 1);
    wait_idle();
    check_result("after_rst", 32'd1);

    // Eight random words with random source gaps and sink stalls
    clear_logs();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back($urandom);
    rand_rx  = 1'b1;
    rand_tx  = 1'b1;
    rand_mem = 1'b1;
    pulse_start();
    send_image(32'd8, 8);
    wait_idle();
    rand_rx  = 1'b0;
    rand_tx  = 1'b0;
    rand_mem = 1'b0;
    step();
    check_result("random", 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
